// File: rtl/can_crc_pkg.sv
// ----------------------------------------------------------------------------
// can_crc_pkg
// Shared definitions for the CAN CRC engine:
//   - crc_state_e : engine states (IDLE, CALC, SEND, RECV, DONE)
//   - CAN_CRC15_POLY / CAN_CRC17_POLY / CAN_CRC21_POLY : generator polynomials
//     for classic CAN and CAN FD, without the implicit x^CRC_W term
// ----------------------------------------------------------------------------
package can_crc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        SEND = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } crc_state_e;

    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
    localparam logic [16:0] CAN_CRC17_POLY = 17'h1685B;
    localparam logic [20:0] CAN_CRC21_POLY = 21'h102899;

endpackage

// File: rtl/can_crc_lfsr.sv
// ----------------------------------------------------------------------------
// can_crc_lfsr
// Combinational single step of a serial CRC register.
// Parameters:
//   CRC_W  register width
//   POLY   generator polynomial without the x^CRC_W term
// Ports:
//   crc_in      current register value
//   data_bit    serial input bit
//   shift_only  1 = plain left shift with zero fill (CRC shift-out),
//               0 = LFSR step with feedback
//   crc_next    register value after the step
// ----------------------------------------------------------------------------
module can_crc_lfsr
    import can_crc_pkg::*;
#(
    parameter int unsigned       CRC_W = 15,
    parameter logic [CRC_W-1:0]  POLY  = CAN_CRC15_POLY
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             data_bit,
    input  logic             shift_only,
    output logic [CRC_W-1:0] crc_next
);

    logic             fb;
    logic [CRC_W-1:0] shifted;

    // Feedback is the incoming bit XOR the register MSB; when only shifting
    // out, feedback is suppressed so the register simply drains to zero.
    always_comb begin
        fb       = data_bit ^ crc_in[CRC_W-1];
        shifted  = {crc_in[CRC_W-2:0], 1'b0};
        crc_next = shifted;
        if (!shift_only && fb) begin
            crc_next = shifted ^ POLY;
        end
    end

endmodule

// File: rtl/can_crc_engine.sv
// ----------------------------------------------------------------------------
// can_crc_engine
// Serial CRC engine for the CAN controller (CRC15 / CRC17 / CRC21 by
// parameter). In transmit mode it accumulates the frame bits and then
// serialises the CRC MSB-first; in receive mode it keeps accumulating through
// the received CRC field and flags a nonzero residue.
//
// Optional build macro: CRC_BIT_CNT_EN adds the bit_cnt data-bit counter port.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse: load INIT, enter CALC, clear crc_err
//   tx_mode        sampled on start; 1 = transmit, 0 = receive/check
//   bit_valid      bit-time strobe
//   data_bit       serial (destuffed) frame bit
//   last_bit       with bit_valid: final data bit before the CRC field
//   busy           high in CALC, SEND, RECV
//   crc_out        current CRC register
//   crc_bit_out    serialised CRC bit (SEND only)
//   crc_bit_valid  high in SEND
//   crc_done       one-cycle completion pulse
//   crc_err        receive residue nonzero, held until next start
//   bit_cnt        data bits consumed in CALC (CRC_BIT_CNT_EN only)
// ----------------------------------------------------------------------------
module can_crc_engine
    import can_crc_pkg::*;
#(
    parameter int unsigned       CRC_W = 15,
    parameter logic [CRC_W-1:0]  POLY  = CAN_CRC15_POLY,
    parameter logic [CRC_W-1:0]  INIT  = '0,
    parameter int unsigned       CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             tx_mode,
    input  logic             bit_valid,
    input  logic             data_bit,
    input  logic             last_bit,
    output logic             busy,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_bit_out,
    output logic             crc_bit_valid,
    output logic             crc_done,
    output logic             crc_err
`ifdef CRC_BIT_CNT_EN
    ,
    output logic [CNT_W-1:0] bit_cnt
`endif
);

    localparam int unsigned        FCNT_W    = $clog2(CRC_W + 1);
    localparam logic [FCNT_W-1:0]  FIELD_LEN = FCNT_W'(CRC_W);

    crc_state_e        state;
    crc_state_e        state_next;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_next;
    logic [FCNT_W-1:0] field_cnt;
    logic              field_last;
    logic              tx_latched;

    // One step function serves both accumulation and shift-out; SEND selects
    // the plain shift so the transmitted register drains to zero.
    can_crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_lfsr (
        .crc_in     (crc_reg),
        .data_bit   (data_bit),
        .shift_only (state == SEND),
        .crc_next   (crc_next)
    );

    assign field_last = (field_cnt == FCNT_W'(1));
    assign crc_out    = crc_reg;

    // State register; start is handled in the next-state logic so an abort
    // from any state behaves like a fresh start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs. start has absolute priority, so a
    // bit_valid arriving in the same cycle is discarded. last_bit only matters
    // in CALC when qualified by bit_valid.
    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        crc_bit_out   = 1'b0;
        crc_bit_valid = 1'b0;
        crc_done      = 1'b0;
        case (state)
            CALC: busy = 1'b1;
            SEND: begin
                busy          = 1'b1;
                crc_bit_out   = crc_reg[CRC_W-1];
                crc_bit_valid = 1'b1;
            end
            RECV: busy = 1'b1;
            DONE: crc_done = 1'b1;
            default: ;
        endcase
        if (start) begin
            state_next = CALC;
        end else begin
            case (state)
                CALC: begin
                    if (bit_valid && last_bit) begin
                        state_next = tx_latched ? SEND : RECV;
                    end
                end
                SEND, RECV: begin
                    if (bit_valid && field_last) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // Datapath: CRC register, CRC field counter, latched mode and the
    // receive error flag. The error is registered on the same edge that
    // moves RECV into DONE, using the updated register value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg    <= INIT;
            field_cnt  <= '0;
            tx_latched <= 1'b0;
            crc_err    <= 1'b0;
        end else if (start) begin
            crc_reg    <= INIT;
            field_cnt  <= '0;
            tx_latched <= tx_mode;
            crc_err    <= 1'b0;
        end else if (bit_valid) begin
            case (state)
                CALC: begin
                    crc_reg <= crc_next;
                    if (last_bit) begin
                        field_cnt <= FIELD_LEN;
                    end
                end
                SEND: begin
                    crc_reg   <= crc_next;
                    field_cnt <= field_cnt - FCNT_W'(1);
                end
                RECV: begin
                    crc_reg   <= crc_next;
                    field_cnt <= field_cnt - FCNT_W'(1);
                    if (field_last) begin
                        crc_err <= (crc_next != '0);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CRC_BIT_CNT_EN
    // Counts data bits accepted in CALC only, saturating at all-ones so a
    // runaway frame cannot wrap back to small values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (start) begin
            bit_cnt <= '0;
        end else if (bit_valid && state == CALC && bit_cnt != '1) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end
`else
    // Counter width is meaningless without the counter; this keeps the
    // parameter referenced so both builds share one parameter list.
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_can_crc_engine.sv
// ----------------------------------------------------------------------------
// tb_can_crc_engine
// Directed self-checking bench for can_crc_engine. A default CRC15 instance
// carries most scenarios; a CRC17 instance shares the same inputs to check a
// CAN FD width. Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_can_crc_engine;
    import can_crc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        tx_mode;
    logic        bit_valid;
    logic        data_bit;
    logic        last_bit;

    logic        busy;
    logic [14:0] crc_out;
    logic        crc_bit_out;
    logic        crc_bit_valid;
    logic        crc_done;
    logic        crc_err;

    logic        busy17;
    logic [16:0] crc_out17;
    logic        crc_bit_out17;
    logic        crc_bit_valid17;
    logic        crc_done17;
    logic        crc_err17;

`ifdef CRC_BIT_CNT_EN
    logic [9:0]  bit_cnt;
    logic [9:0]  bit_cnt17;
`endif

    int checks = 0;
    int passed = 0;

    can_crc_engine u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .tx_mode       (tx_mode),
        .bit_valid     (bit_valid),
        .data_bit      (data_bit),
        .last_bit      (last_bit),
        .busy          (busy),
        .crc_out       (crc_out),
        .crc_bit_out   (crc_bit_out),
        .crc_bit_valid (crc_bit_valid),
        .crc_done      (crc_done),
        .crc_err       (crc_err)
`ifdef CRC_BIT_CNT_EN
        ,
        .bit_cnt       (bit_cnt)
`endif
    );

    can_crc_engine #(
        .CRC_W (17),
        .POLY  (CAN_CRC17_POLY),
        .INIT  (17'h0)
    ) u_dut17 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .tx_mode       (tx_mode),
        .bit_valid     (bit_valid),
        .data_bit      (data_bit),
        .last_bit      (last_bit),
        .busy          (busy17),
        .crc_out       (crc_out17),
        .crc_bit_out   (crc_bit_out17),
        .crc_bit_valid (crc_bit_valid17),
        .crc_done      (crc_done17),
        .crc_err       (crc_err17)
`ifdef CRC_BIT_CNT_EN
        ,
        .bit_cnt       (bit_cnt17)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bit-time strobe: driven at a falling edge, consumed at the rising
    // edge, released and ready for sampling at the next falling edge.
    task automatic strobe(input logic d, input logic l);
        bit_valid = 1'b1;
        data_bit  = d;
        last_bit  = l;
        @(negedge clk);
        bit_valid = 1'b0;
        data_bit  = 1'b0;
        last_bit  = 1'b0;
    endtask

    task automatic start_pulse(input logic m);
        start   = 1'b1;
        tx_mode = m;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; tx_mode = 1'b0;
        bit_valid = 1'b0; data_bit = 1'b0; last_bit = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (crc_out !== 15'h0) $display("[TB] FAIL reset_crc: got %h expected 0000", crc_out); else passed++;
        checks++; if ({crc_bit_out, crc_bit_valid, crc_done, crc_err} !== 4'b0) $display("[TB] FAIL reset_flags: got %b expected 0000", {crc_bit_out, crc_bit_valid, crc_done, crc_err}); else passed++;
`ifdef CRC_BIT_CNT_EN
        checks++; if (bit_cnt !== 10'd0) $display("[TB] FAIL reset_bitcnt: got %0d expected 0", bit_cnt); else passed++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
        strobe(1'b1, 1'b1);
        checks++; if (crc_out !== 15'h0 || busy !== 1'b0) $display("[TB] FAIL idle_ignores_bits: got crc %h busy %b expected 0000 0", crc_out, busy); else passed++;
    endtask

    task automatic test_tx_single;
        logic [14:0] exp_bits;
        exp_bits = 15'b100010110011001;
        start_pulse(1'b1);
        checks++; if (busy !== 1'b1 || crc_out !== 15'h0) $display("[TB] FAIL tx_start: got busy %b crc %h expected 1 0000", busy, crc_out); else passed++;
        strobe(1'b1, 1'b1);
        checks++; if (crc_out !== 15'h4599) $display("[TB] FAIL tx_single_crc: got %h expected 4599", crc_out); else passed++;
        checks++; if (crc_out17 !== 17'h1685B) $display("[TB] FAIL crc17_single_crc: got %h expected 1685b", crc_out17); else passed++;
        for (int i = 14; i >= 0; i--) begin
            checks++; if (crc_bit_valid !== 1'b1 || crc_bit_out !== exp_bits[i]) $display("[TB] FAIL tx_bit%0d: got valid %b bit %b expected 1 %b", i, crc_bit_valid, crc_bit_out, exp_bits[i]); else passed++;
            strobe(1'($urandom_range(0, 1)), (i == 7) ? 1'b1 : 1'b0);
        end
        checks++; if (crc_done !== 1'b1 || busy !== 1'b0 || crc_out !== 15'h0) $display("[TB] FAIL tx_done: got done %b busy %b crc %h expected 1 0 0000", crc_done, busy, crc_out); else passed++;
        checks++; if (crc_bit_valid !== 1'b0) $display("[TB] FAIL tx_done_valid: got %b expected 0", crc_bit_valid); else passed++;
        @(negedge clk);
        checks++; if (crc_done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL tx_done_pulse: got done %b busy %b expected 0 0", crc_done, busy); else passed++;
    endtask

    task automatic test_two_bits;
        start_pulse(1'b1);
        strobe(1'b1, 1'b0);
        checks++; if (crc_out !== 15'h4599 || crc_bit_valid !== 1'b0) $display("[TB] FAIL two_bits_first: got crc %h valid %b expected 4599 0", crc_out, crc_bit_valid); else passed++;
        strobe(1'b0, 1'b1);
        checks++; if (crc_out !== 15'h4EAB || crc_bit_valid !== 1'b1) $display("[TB] FAIL two_bits_second: got crc %h valid %b expected 4eab 1", crc_out, crc_bit_valid); else passed++;
        start_pulse(1'b1);
        checks++; if (crc_out !== 15'h0 || crc_bit_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL abort_send: got crc %h valid %b busy %b expected 0000 0 1", crc_out, crc_bit_valid, busy); else passed++;
    endtask

    task automatic test_rx(input logic flip, input logic [14:0] exp_crc);
        logic [14:0] field;
        field = 15'h4599 ^ {14'b0, flip};
        start_pulse(1'b0);
        strobe(1'b1, 1'b1);
        checks++; if (crc_bit_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL rx_enter: got valid %b busy %b expected 0 1", crc_bit_valid, busy); else passed++;
        for (int i = 14; i >= 0; i--) begin
            strobe(field[i], 1'b1);
        end
        checks++; if (crc_done !== 1'b1 || crc_err !== flip || crc_out !== exp_crc) $display("[TB] FAIL rx_done_flip%0d: got done %b err %b crc %h expected 1 %b %h", flip, crc_done, crc_err, crc_out, flip, exp_crc); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (crc_err !== flip || crc_done !== 1'b0) $display("[TB] FAIL rx_err_hold_flip%0d: got err %b done %b expected %b 0", flip, crc_err, crc_done, flip); else passed++;
        start_pulse(1'b0);
        checks++; if (crc_err !== 1'b0) $display("[TB] FAIL rx_err_clear: got %b expected 0", crc_err); else passed++;
    endtask

    task automatic test_abort_priority;
        start_pulse(1'b1);
        strobe(1'b1, 1'b0);
        start     = 1'b1;
        tx_mode   = 1'b1;
        bit_valid = 1'b1;
        data_bit  = 1'b1;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0; data_bit = 1'b0;
        checks++; if (crc_out !== 15'h0 || busy !== 1'b1 || crc_bit_valid !== 1'b0) $display("[TB] FAIL start_wins: got crc %h busy %b valid %b expected 0000 1 0", crc_out, busy, crc_bit_valid); else passed++;
        last_bit = 1'b1;
        @(negedge clk);
        last_bit = 1'b0;
        checks++; if (crc_out !== 15'h0 || crc_bit_valid !== 1'b0) $display("[TB] FAIL lone_last_bit: got crc %h valid %b expected 0000 0", crc_out, crc_bit_valid); else passed++;
        strobe(1'b1, 1'b1);
        checks++; if (crc_out !== 15'h4599 || crc_bit_valid !== 1'b1) $display("[TB] FAIL after_abort: got crc %h valid %b expected 4599 1", crc_out, crc_bit_valid); else passed++;
    endtask

    task automatic test_reset_mid_send;
        start_pulse(1'b1);
        strobe(1'b1, 1'b1);
        repeat (3) strobe(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (crc_out !== 15'h0 || busy !== 1'b0 || crc_bit_valid !== 1'b0 || crc_bit_out !== 1'b0 || crc_done !== 1'b0) $display("[TB] FAIL reset_mid_send: got crc %h busy %b valid %b bit %b done %b expected 0000 0 0 0 0", crc_out, busy, crc_bit_valid, crc_bit_out, crc_done); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef CRC_BIT_CNT_EN
    task automatic test_bit_cnt;
        start_pulse(1'b1);
        checks++; if (bit_cnt !== 10'd0) $display("[TB] FAIL bitcnt_start: got %0d expected 0", bit_cnt); else passed++;
        for (int i = 0; i < 36; i++) begin
            strobe(1'(i % 3 == 0), 1'b0);
        end
        strobe(1'b1, 1'b1);
        checks++; if (bit_cnt !== 10'd37) $display("[TB] FAIL bitcnt_37: got %0d expected 37", bit_cnt); else passed++;
        repeat (15) strobe(1'b1, 1'b0);
        checks++; if (bit_cnt !== 10'd37 || crc_done !== 1'b1) $display("[TB] FAIL bitcnt_frozen: got cnt %0d done %b expected 37 1", bit_cnt, crc_done); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_tx_single();
        test_two_bits();
        test_rx(1'b0, 15'h0000);
        test_rx(1'b1, 15'h4599);
        test_abort_priority();
        test_reset_mid_send();
`ifdef CRC_BIT_CNT_EN
        test_bit_cnt();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
